// File: rtl/microwave_countdown_pkg.sv
// ---------------------------------------------------------------------------
// microwave_countdown_pkg
// Shared types and constants for the cooking-time countdown block:
//   - state_t      : controller states (IDLE, RUN, PAUSE, DONE)
//   - BCD_W        : width of one BCD digit
//   - DIGIT_MAX    : largest legal BCD digit (9)
//   - SEC_TENS_MAX : largest legal seconds-tens digit (5)
//   - clamp_digit  : saturates a keypad digit to a given maximum
// ---------------------------------------------------------------------------
package microwave_countdown_pkg;

    localparam int BCD_W = 4;

    localparam logic [BCD_W-1:0] DIGIT_MAX    = 4'd9;
    localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Saturate an incoming keypad digit so the held value is always valid BCD mm:ss.
    function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] d,
                                                     input logic [BCD_W-1:0] lim);
        logic [BCD_W-1:0] r;
        if (d > lim) begin
            r = lim;
        end else begin
            r = d;
        end
        return r;
    endfunction

endpackage

// File: rtl/microwave_countdown_if.sv
// ---------------------------------------------------------------------------
// microwave_countdown_if
// Command/status bundle between the divider/keypad front end (master) and
// the countdown block (slave).
//   master drives : tick, load, load_mt/mo/st/so, start, pause, clear
//   slave drives  : min_tens/min_ones/sec_tens/sec_ones, running, finished, done
// ---------------------------------------------------------------------------
interface microwave_countdown_if;
    import microwave_countdown_pkg::*;

    logic             tick;
    logic             load;
    logic [BCD_W-1:0] load_mt;
    logic [BCD_W-1:0] load_mo;
    logic [BCD_W-1:0] load_st;
    logic [BCD_W-1:0] load_so;
    logic             start;
    logic             pause;
    logic             clear;

    logic [BCD_W-1:0] min_tens;
    logic [BCD_W-1:0] min_ones;
    logic [BCD_W-1:0] sec_tens;
    logic [BCD_W-1:0] sec_ones;
    logic             running;
    logic             finished;
    logic             done;

    modport master (
        output tick, load, load_mt, load_mo, load_st, load_so, start, pause, clear,
        input  min_tens, min_ones, sec_tens, sec_ones, running, finished, done
    );

    modport slave (
        input  tick, load, load_mt, load_mo, load_st, load_so, start, pause, clear,
        output min_tens, min_ones, sec_tens, sec_ones, running, finished, done
    );

endinterface

// File: rtl/microwave_countdown_bcd_down_digit.sv
// ---------------------------------------------------------------------------
// bcd_down_digit
// One stage of a BCD down-counter borrow chain (purely combinational).
//   digit      : current digit value
//   enable     : a decrement step is requested this cycle
//   borrow_in  : the lower stage needs a borrow (tie high on the lowest stage)
//   next_digit : digit value after the step
//   borrow_out : this stage wrapped from 0 to WRAP and borrows from the next
// ---------------------------------------------------------------------------
module bcd_down_digit
    import microwave_countdown_pkg::*;
#(
    parameter logic [BCD_W-1:0] WRAP = DIGIT_MAX
) (
    input  logic [BCD_W-1:0] digit,
    input  logic             enable,
    input  logic             borrow_in,
    output logic [BCD_W-1:0] next_digit,
    output logic             borrow_out
);

    // Decrement with wrap-around; the stage only moves when a borrow reaches it.
    always_comb begin
        next_digit = digit;
        borrow_out = 1'b0;
        if (enable && borrow_in) begin
            if (digit == 4'd0) begin
                next_digit = WRAP;
                borrow_out = 1'b1;
            end else begin
                next_digit = digit - 4'd1;
                borrow_out = 1'b0;
            end
        end else begin
            next_digit = digit;
            borrow_out = 1'b0;
        end
    end

endmodule

// File: rtl/microwave_countdown.sv
// ---------------------------------------------------------------------------
// microwave_countdown
// Cooking-time countdown: holds a BCD mm:ss value, decrements it once per
// 1 Hz tick while running, and flags expiry.
//   clock : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : microwave_countdown_if.slave (commands in, digits/flags out)
// Parameter LOAD_IN_RUN: 1 = load accepted while running (stays in RUN),
//                        0 = load ignored while running.
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module microwave_countdown
    import microwave_countdown_pkg::*;
#(
    parameter bit LOAD_IN_RUN = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    microwave_countdown_if.slave  bus
);

    state_t           state_r;
    logic [BCD_W-1:0] min_tens_r;
    logic [BCD_W-1:0] min_ones_r;
    logic [BCD_W-1:0] sec_tens_r;
    logic [BCD_W-1:0] sec_ones_r;
    logic             running_r;
    logic             finished_r;
    logic             done_r;

    logic [BCD_W-1:0] nxt_mt_s;
    logic [BCD_W-1:0] nxt_mo_s;
    logic [BCD_W-1:0] nxt_st_s;
    logic [BCD_W-1:0] nxt_so_s;
    logic             brw_so_s;
    logic             brw_st_s;
    logic             brw_mo_s;
    logic             underflow_s;
    logic             step_s;
    logic             zero_s;
    logic             nxt_zero_s;

    logic [BCD_W-1:0] clamp_mt_s;
    logic [BCD_W-1:0] clamp_mo_s;
    logic [BCD_W-1:0] clamp_st_s;
    logic [BCD_W-1:0] clamp_so_s;

    assign step_s = bus.tick && (state_r == RUN);

    // One-second borrow chain, lowest digit first.
    bcd_down_digit #(.WRAP(DIGIT_MAX)) u_so (
        .digit(sec_ones_r), .enable(step_s), .borrow_in(1'b1),
        .next_digit(nxt_so_s), .borrow_out(brw_so_s)
    );
    bcd_down_digit #(.WRAP(SEC_TENS_MAX)) u_st (
        .digit(sec_tens_r), .enable(step_s), .borrow_in(brw_so_s),
        .next_digit(nxt_st_s), .borrow_out(brw_st_s)
    );
    bcd_down_digit #(.WRAP(DIGIT_MAX)) u_mo (
        .digit(min_ones_r), .enable(step_s), .borrow_in(brw_st_s),
        .next_digit(nxt_mo_s), .borrow_out(brw_mo_s)
    );
    // A borrow out of the top digit means the count was already 00:00.
    bcd_down_digit #(.WRAP(DIGIT_MAX)) u_mt (
        .digit(min_tens_r), .enable(step_s), .borrow_in(brw_mo_s),
        .next_digit(nxt_mt_s), .borrow_out(underflow_s)
    );

    assign zero_s     = (min_tens_r == 4'd0) && (min_ones_r == 4'd0) &&
                        (sec_tens_r == 4'd0) && (sec_ones_r == 4'd0);
    assign nxt_zero_s = (nxt_mt_s == 4'd0) && (nxt_mo_s == 4'd0) &&
                        (nxt_st_s == 4'd0) && (nxt_so_s == 4'd0);

    assign clamp_mt_s = clamp_digit(bus.load_mt, DIGIT_MAX);
    assign clamp_mo_s = clamp_digit(bus.load_mo, DIGIT_MAX);
    assign clamp_st_s = clamp_digit(bus.load_st, SEC_TENS_MAX);
    assign clamp_so_s = clamp_digit(bus.load_so, DIGIT_MAX);

    // Controller FSM: command priority clear > load > pause > start > tick.
    // An asserted command claims its priority slot even when the current
    // state ignores it, so lower-priority commands and ticks are dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= IDLE;
            min_tens_r <= 4'd0;
            min_ones_r <= 4'd0;
            sec_tens_r <= 4'd0;
            sec_ones_r <= 4'd0;
            running_r  <= 1'b0;
            finished_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (bus.clear) begin
                state_r    <= IDLE;
                min_tens_r <= 4'd0;
                min_ones_r <= 4'd0;
                sec_tens_r <= 4'd0;
                sec_ones_r <= 4'd0;
                running_r  <= 1'b0;
                finished_r <= 1'b0;
            end else if (bus.load) begin
                if (state_r != RUN) begin
                    state_r    <= IDLE;
                    min_tens_r <= clamp_mt_s;
                    min_ones_r <= clamp_mo_s;
                    sec_tens_r <= clamp_st_s;
                    sec_ones_r <= clamp_so_s;
                    running_r  <= 1'b0;
                    finished_r <= 1'b0;
                end else if (LOAD_IN_RUN) begin
                    min_tens_r <= clamp_mt_s;
                    min_ones_r <= clamp_mo_s;
                    sec_tens_r <= clamp_st_s;
                    sec_ones_r <= clamp_so_s;
                end else begin
                    state_r <= state_r;
                end
            end else if (bus.pause) begin
                if (state_r == RUN) begin
                    state_r   <= PAUSE;
                    running_r <= 1'b0;
                end else begin
                    state_r <= state_r;
                end
            end else if (bus.start) begin
                if (((state_r == IDLE) || (state_r == PAUSE)) && !zero_s) begin
                    state_r   <= RUN;
                    running_r <= 1'b1;
                end else begin
                    state_r <= state_r;
                end
            end else if (step_s) begin
                // 00:00 can only be in RUN after a run-time load of zero;
                // expire without decrementing so the count never wraps.
                if (underflow_s) begin
                    state_r    <= DONE;
                    running_r  <= 1'b0;
                    finished_r <= 1'b1;
                    done_r     <= 1'b1;
                end else begin
                    min_tens_r <= nxt_mt_s;
                    min_ones_r <= nxt_mo_s;
                    sec_tens_r <= nxt_st_s;
                    sec_ones_r <= nxt_so_s;
                    if (nxt_zero_s) begin
                        state_r    <= DONE;
                        running_r  <= 1'b0;
                        finished_r <= 1'b1;
                        done_r     <= 1'b1;
                    end else begin
                        state_r <= state_r;
                    end
                end
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign bus.min_tens = min_tens_r;
    assign bus.min_ones = min_ones_r;
    assign bus.sec_tens = sec_tens_r;
    assign bus.sec_ones = sec_ones_r;
    assign bus.running  = running_r;
    assign bus.finished = finished_r;
    assign bus.done     = done_r;

endmodule
